// File: rtl/dma_axi_defs.sv
// Shared AXI encodings and write-master FSM states for the DMA read/write masters.
package dma_axi_defs;

    localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [31:0] BOUNDARY_4K     = 32'h0000_1000;
    localparam logic [31:0] MAX_BURST_BYTES = 32'd64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

endpackage

// File: rtl/axi_burst_calc.sv
// Burst sizing: bytes = min(remaining, max burst, distance to next 4 KB page), plus beat count.
module axi_burst_calc
    import dma_axi_defs::*;
#(
    parameter int MAX_BEATS = 16
) (
    input  logic [11:0] i_addr_4k,
    input  logic [31:0] i_remaining,
    output logic [31:0] o_bytes,
    output logic [7:0]  o_beats
);

    localparam logic [31:0] LIMIT_BYTES = 32'(MAX_BEATS * 4);

    logic [31:0] to_4k;
    logic [31:0] cap;

    always_comb begin
        to_4k   = BOUNDARY_4K - {20'd0, i_addr_4k};
        cap     = (LIMIT_BYTES < to_4k) ? LIMIT_BYTES : to_4k;
        o_bytes = (i_remaining < cap) ? i_remaining : cap;
        o_beats = 8'(o_bytes >> 2);
    end

endmodule

// File: rtl/axi_write_master.sv
// AXI4 write master: drains the transfer FIFO to memory as INCR bursts, one burst in flight.
//
// state | meaning
// IDLE  | waiting for i_start
// ADDR  | AW presented, waiting for awready
// DATA  | streaming W beats from the FIFO
// RESP  | waiting for the B response of the current burst
module axi_write_master
    import dma_axi_defs::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int MAX_BURST_BEATS    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [31:0]                   i_total_len,
    output logic                          o_write_done,
    output logic                          o_busy,
    output logic                          o_error,
    input  logic                          i_fifo_empty,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] i_w_data,
    output logic                          o_fifo_pop,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;

    wr_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [31:0]   remaining_q, remaining_d;
    logic [31:0]   bytes_q, bytes_d;
    logic [7:0]    awlen_q, awlen_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic          awvalid_q, awvalid_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [31:0]   calc_bytes;
    logic [7:0]    calc_beats;
    logic          w_hs;

    // Sized from the next-state address so awaddr/awlen are ready the cycle ADDR is entered.
    axi_burst_calc #(.MAX_BEATS(MAX_BURST_BEATS)) u_burst_calc (
        .i_addr_4k   (addr_d[11:0]),
        .i_remaining (remaining_d),
        .o_bytes     (calc_bytes),
        .o_beats     (calc_beats)
    );

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = i_w_data;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = (beat_cnt_q == awlen_q);
    assign m_axi_wvalid  = (state_q == ST_DATA) & ~i_fifo_empty;
    assign m_axi_bready  = (state_q == ST_RESP);
    assign o_fifo_pop    = w_hs;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_write_done  = done_q;
    assign o_error       = error_q;
    assign w_hs          = m_axi_wvalid & m_axi_wready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        awvalid_d   = awvalid_q;
        done_d      = 1'b0;
        error_d     = error_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d      = i_dst_addr;
                    remaining_d = i_total_len & ~32'h3;
                    error_d     = 1'b0;
                    if (remaining_d == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_ADDR;
                        awvalid_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (m_axi_awready) begin
                    awvalid_d  = 1'b0;
                    beat_cnt_d = 8'd0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (m_axi_wlast) begin
                        beat_cnt_d = 8'd0;
                        state_d    = ST_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != AXI_RESP_OKAY) error_d = 1'b1;
                    addr_d      = addr_q + AW'(bytes_q);
                    remaining_d = remaining_q - bytes_q;
                    if (remaining_d == 32'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        awvalid_d = 1'b1;
                        state_d   = ST_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        awaddr_d = awaddr_q;
        awlen_d  = awlen_q;
        bytes_d  = bytes_q;
        if (state_d == ST_ADDR && state_q != ST_ADDR) begin
            awaddr_d = addr_d;
            awlen_d  = calc_beats - 8'd1;
            bytes_d  = calc_bytes;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            awaddr_q    <= '0;
            remaining_q <= '0;
            bytes_q     <= '0;
            awlen_q     <= '0;
            beat_cnt_q  <= '0;
            awvalid_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            awaddr_q    <= awaddr_d;
            remaining_q <= remaining_d;
            bytes_q     <= bytes_d;
            awlen_q     <= awlen_d;
            beat_cnt_q  <= beat_cnt_d;
            awvalid_q   <= awvalid_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_axi_write_master.sv
// Scoreboard bench for axi_write_master: directed transfers with expected AW/W/done queues.
module tb_axi_write_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic [31:0] i_dst_addr;
    logic [31:0] i_total_len;
    logic        o_write_done, o_busy, o_error;
    logic        i_fifo_empty;
    logic [31:0] i_w_data;
    logic        o_fifo_pop;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;

    always #5 clk = ~clk;

    axi_write_master dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_dst_addr(i_dst_addr),
        .i_total_len(i_total_len), .o_write_done(o_write_done), .o_busy(o_busy),
        .o_error(o_error), .i_fifo_empty(i_fifo_empty), .i_w_data(i_w_data),
        .o_fifo_pop(o_fifo_pop), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] fifo_q[$];
    logic [39:0] exp_aw_q[$];   // {awlen, awaddr}
    logic [32:0] exp_w_q[$];    // {wlast, wdata}
    logic [1:0]  bresp_q[$];

    int  bursts_left = 0;
    int  b_due       = 0;
    int  pop_count   = 0;
    int  word_ctr    = 0;
    bit  pop_flag    = 0;
    bit  b_hs        = 0;
    bit  exp_done    = 0;
    bit  hold_aw     = 0;
    bit  hold_w      = 0;
    bit  aw_open     = 0;
    bit  en_stall    = 0;
    bit  stall_e     = 0;
    logic [31:0] prev_awaddr, prev_wdata;
    logic [7:0]  prev_awlen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave-side driver: FIFO head, ready stalls, B responses.
    initial begin
        i_fifo_empty  = 1'b1;
        i_w_data      = '0;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                m_axi_bvalid = 1'b0;
                b_hs         = 0;
            end else begin
                if (pop_flag) begin
                    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                    pop_flag = 0;
                end
                if (b_hs) begin
                    m_axi_bvalid = 1'b0;
                    b_hs         = 0;
                end
                if (!hold_w) stall_e = en_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
                m_axi_wready  = en_stall ? 1'($urandom_range(0, 1)) : 1'b1;
                m_axi_awready = en_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (b_due > 0 && !m_axi_bvalid && (!en_stall || $urandom_range(0, 1) == 1)) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                    b_due--;
                end
            end
            i_fifo_empty = stall_e || (fifo_q.size() == 0);
            i_w_data     = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        end
    end

    // Monitor: compares DUT handshakes against the expected queues.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_aw = 0;
            hold_w  = 0;
            exp_done = 0;
        end else begin
            if (exp_done || o_write_done) check("write_done", {31'd0, o_write_done}, {31'd0, exp_done});
            exp_done = 0;
            if (m_axi_wvalid || o_fifo_pop)
                check("fifo_pop", {31'd0, o_fifo_pop}, {31'd0, m_axi_wvalid & m_axi_wready});
            if (hold_aw) begin
                check("aw_hold_valid", {31'd0, m_axi_awvalid}, 32'd1);
                check("aw_hold_addr", m_axi_awaddr, prev_awaddr);
                check("aw_hold_len", {24'd0, m_axi_awlen}, {24'd0, prev_awlen});
            end
            if (hold_w) begin
                check("w_hold_valid", {31'd0, m_axi_wvalid}, 32'd1);
                check("w_hold_data", m_axi_wdata, prev_wdata);
            end
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_aw_q.size() == 0) begin
                    check("aw_unexpected", {31'd0, m_axi_awvalid}, 32'd0);
                end else begin
                    logic [39:0] e;
                    e = exp_aw_q.pop_front();
                    check("awaddr", m_axi_awaddr, e[31:0]);
                    check("awlen", {24'd0, m_axi_awlen}, {24'd0, e[39:32]});
                    check("awsize", {29'd0, m_axi_awsize}, 32'd2);
                    check("awburst", {30'd0, m_axi_awburst}, 32'd1);
                end
                aw_open = 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                pop_flag = 1;
                pop_count++;
                check("w_after_aw", {31'd0, aw_open}, 32'd1);
                if (exp_w_q.size() == 0) begin
                    check("w_unexpected", {31'd0, m_axi_wvalid}, 32'd0);
                end else begin
                    logic [32:0] w;
                    w = exp_w_q.pop_front();
                    check("wdata", m_axi_wdata, w[31:0]);
                    check("wlast", {31'd0, m_axi_wlast}, {31'd0, w[32]});
                    check("wstrb", {28'd0, m_axi_wstrb}, 32'hF);
                end
                if (m_axi_wlast) begin
                    aw_open = 0;
                    b_due++;
                end
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_hs = 1;
                bursts_left--;
                if (bursts_left == 0) exp_done = 1;
            end
            if (i_start && !o_busy && i_total_len[31:2] == 30'd0) exp_done = 1;
            hold_aw     = m_axi_awvalid & ~m_axi_awready;
            hold_w      = m_axi_wvalid & ~m_axi_wready;
            prev_awaddr = m_axi_awaddr;
            prev_awlen  = m_axi_awlen;
            prev_wdata  = m_axi_wdata;
        end
    end

    task automatic add_burst(input logic [31:0] addr, input logic [7:0] len);
        logic [31:0] d;
        exp_aw_q.push_back({len, addr});
        for (int i = 0; i <= int'(len); i++) begin
            d = {16'hA5C3, 16'(word_ctr)};
            fifo_q.push_back(d);
            exp_w_q.push_back({(i == int'(len)), d});
            word_ctr++;
        end
        bursts_left++;
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [31:0] l);
        @(posedge clk); #1;
        i_dst_addr  = a;
        i_total_len = l;
        i_start     = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (o_write_done) seen = 1;
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_aw_left"}, 32'(exp_aw_q.size()), 32'd0);
        check({name, "_w_left"}, 32'(exp_w_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check({name, "_busy"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        int  pc0;
        bit  got;
        reset_n     = 1'b0;
        i_start     = 1'b0;
        i_dst_addr  = '0;
        i_total_len = '0;
        #23;
        check("rst_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_write_done}, 32'd0);
        check("rst_error", {31'd0, o_error}, 32'd0);
        check("rst_bready", {31'd0, m_axi_bready}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // single 16 B burst
        add_burst(32'h1000, 8'd3);
        start_xfer(32'h1000, 32'd16);
        wait_done("t1");

        // 4 KB split
        pc0 = pop_count;
        add_burst(32'h0FF0, 8'd3);
        add_burst(32'h1000, 8'd11);
        start_xfer(32'h0FF0, 32'd64);
        wait_done("t2");
        check("t2_pops", 32'(pop_count - pc0), 32'd16);

        // 200 B over four bursts; a stray i_start mid-transfer must be ignored
        pc0 = pop_count;
        add_burst(32'h2000, 8'd15);
        add_burst(32'h2040, 8'd15);
        add_burst(32'h2080, 8'd15);
        add_burst(32'h20C0, 8'd1);
        start_xfer(32'h2000, 32'd200);
        repeat (5) @(posedge clk);
        #1 i_dst_addr = 32'h9000; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        wait_done("t3");
        check("t3_pops", 32'(pop_count - pc0), 32'd50);

        // random stalls, page crossing, 100 B
        en_stall = 1;
        add_burst(32'h0FE8, 8'd5);
        add_burst(32'h1000, 8'd15);
        add_burst(32'h1040, 8'd2);
        start_xfer(32'h0FE8, 32'd100);
        wait_done("t4");
        en_stall = 0;
        @(posedge clk); #1;

        // error response on the middle burst; transfer still completes
        add_burst(32'h3000, 8'd15);
        add_burst(32'h3040, 8'd15);
        add_burst(32'h3080, 8'd15);
        bresp_q.push_back(2'b00);
        bresp_q.push_back(2'b10);
        bresp_q.push_back(2'b00);
        start_xfer(32'h3000, 32'd192);
        wait_done("t5");
        check("t5_error", {31'd0, o_error}, 32'd1);

        // sub-word length: done with no AW, and o_error cleared by the start
        start_xfer(32'h3100, 32'd3);
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            if (o_write_done) got = 1; else @(negedge clk);
        end
        check("t6_done_seen", {31'd0, got}, 32'd1);
        check("t6_error_clr", {31'd0, o_error}, 32'd0);
        repeat (2) @(negedge clk);

        // length bits [1:0] ignored: 19 -> 16 bytes
        add_burst(32'h3200, 8'd3);
        start_xfer(32'h3200, 32'd19);
        wait_done("t7");

        // reset mid-DATA
        add_burst(32'h4000, 8'd15);
        start_xfer(32'h4000, 32'd64);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (m_axi_wvalid && m_axi_wready) got = 1;
        end
        check("t8_in_data", {31'd0, got}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t8_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
        check("t8_wvalid", {31'd0, m_axi_wvalid}, 32'd0);
        check("t8_bready", {31'd0, m_axi_bready}, 32'd0);
        check("t8_busy", {31'd0, o_busy}, 32'd0);
        fifo_q.delete();
        exp_aw_q.delete();
        exp_w_q.delete();
        bresp_q.delete();
        b_due       = 0;
        bursts_left = 0;
        pop_flag    = 0;
        aw_open     = 0;
        stall_e     = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // recovery after reset
        add_burst(32'h5000, 8'd1);
        start_xfer(32'h5000, 32'd8);
        wait_done("t9");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
